// File: rtl/ex_operand_fwd.sv
// EX-stage operand forwarding register: picks each source operand from XZR, EX/MEM, MEM/WB or the register file.
// Latency: 1 cycle from ID inputs to op_a/op_b, fwd_a/fwd_b and out_valid.
// Backpressure: stall holds every output register; flush clears the stage and wins over stall.
module ex_operand_fwd (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic [4:0]  rn_addr,
  input  logic [4:0]  rm_addr,
  input  logic [63:0] rn_data,
  input  logic [63:0] rm_data,
  input  logic        exmem_wr,
  input  logic [4:0]  exmem_addr,
  input  logic [63:0] exmem_data,
  input  logic        memwb_wr,
  input  logic [4:0]  memwb_addr,
  input  logic [63:0] memwb_data,
  output logic [63:0] op_a,
  output logic [63:0] op_b,
  output logic        out_valid,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] fwd_count
);

  localparam logic [1:0] TAG_RF    = 2'b00;
  localparam logic [1:0] TAG_MEMWB = 2'b01;
  localparam logic [1:0] TAG_EXMEM = 2'b10;
  localparam logic [1:0] TAG_XZR   = 2'b11;

  // Returns {tag, data}. XZR beats any match; EX/MEM is younger than MEM/WB so it wins.
  function automatic logic [65:0] pick_operand(
    input logic [4:0]  addr,
    input logic [63:0] rf_data,
    input logic        ex_wr,
    input logic [4:0]  ex_addr,
    input logic [63:0] ex_data,
    input logic        wb_wr,
    input logic [4:0]  wb_addr,
    input logic [63:0] wb_data
  );
    logic [65:0] res;
    if (addr == 5'd31) begin
      res = {TAG_XZR, 64'd0};
    end else if (ex_wr && (ex_addr == addr)) begin
      res = {TAG_EXMEM, ex_data};
    end else if (wb_wr && (wb_addr == addr)) begin
      res = {TAG_MEMWB, wb_data};
    end else begin
      res = {TAG_RF, rf_data};
    end
    return res;
  endfunction

  logic [65:0] sel_a;
  logic [65:0] sel_b;
  logic [1:0]  fwd_inc;
  logic [16:0] count_sum;
  logic [15:0] count_next;

  // Combinational operand selection for both sources.
  always_comb begin
    sel_a = pick_operand(rn_addr, rn_data, exmem_wr, exmem_addr, exmem_data,
                         memwb_wr, memwb_addr, memwb_data);
    sel_b = pick_operand(rm_addr, rm_data, exmem_wr, exmem_addr, exmem_data,
                         memwb_wr, memwb_addr, memwb_data);
  end

  // Saturating forward counter: count pipeline-forwarded operands (tags 01/10 only).
  always_comb begin
    fwd_inc = 2'd0;
    if (sel_a[65:64] == TAG_MEMWB || sel_a[65:64] == TAG_EXMEM) fwd_inc = fwd_inc + 2'd1;
    if (sel_b[65:64] == TAG_MEMWB || sel_b[65:64] == TAG_EXMEM) fwd_inc = fwd_inc + 2'd1;
    count_sum  = {1'b0, fwd_count} + {15'd0, fwd_inc};
    count_next = count_sum[16] ? 16'hFFFF : count_sum[15:0];
  end

  // Stage register: flush over stall over normal load; operands load even for bubbles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a      <= 64'd0;
      op_b      <= 64'd0;
      fwd_a     <= TAG_RF;
      fwd_b     <= TAG_RF;
      out_valid <= 1'b0;
      fwd_count <= 16'd0;
    end else if (flush) begin
      op_a      <= 64'd0;
      op_b      <= 64'd0;
      fwd_a     <= TAG_RF;
      fwd_b     <= TAG_RF;
      out_valid <= 1'b0;
    end else if (!stall) begin
      op_a      <= sel_a[63:0];
      op_b      <= sel_b[63:0];
      fwd_a     <= sel_a[65:64];
      fwd_b     <= sel_b[65:64];
      out_valid <= in_valid;
      if (in_valid) fwd_count <= count_next;
    end
  end

endmodule

// File: tb/tb_ex_operand_fwd.sv
// Directed bench for ex_operand_fwd: hand-computed vectors for selection, control priority,
// saturation and asynchronous reset. Inputs change 1 time unit after a rising edge,
// outputs are sampled 1 time unit after the edge that loads them.
module tb_ex_operand_fwd;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, stall, flush;
  logic [4:0]  rn_addr, rm_addr;
  logic [63:0] rn_data, rm_data;
  logic        exmem_wr;
  logic [4:0]  exmem_addr;
  logic [63:0] exmem_data;
  logic        memwb_wr;
  logic [4:0]  memwb_addr;
  logic [63:0] memwb_data;
  logic [63:0] op_a, op_b;
  logic        out_valid;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] fwd_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_operand_fwd dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .stall      (stall),
    .flush      (flush),
    .rn_addr    (rn_addr),
    .rm_addr    (rm_addr),
    .rn_data    (rn_data),
    .rm_data    (rm_data),
    .exmem_wr   (exmem_wr),
    .exmem_addr (exmem_addr),
    .exmem_data (exmem_data),
    .memwb_wr   (memwb_wr),
    .memwb_addr (memwb_addr),
    .memwb_data (memwb_data),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .fwd_count  (fwd_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic v, input logic [1:0] ta, input logic [1:0] tb,
                           input logic [15:0] cnt);
    check({tag, ".op_a"}, op_a, a);
    check({tag, ".op_b"}, op_b, b);
    check({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, v});
    check({tag, ".fwd_a"}, {62'd0, fwd_a}, {62'd0, ta});
    check({tag, ".fwd_b"}, {62'd0, fwd_b}, {62'd0, tb});
    check({tag, ".fwd_count"}, {48'd0, fwd_count}, {48'd0, cnt});
  endtask

  task automatic set_ops(input logic [4:0] ra, input logic [63:0] da,
                         input logic [4:0] rb, input logic [63:0] db);
    rn_addr = ra; rn_data = da; rm_addr = rb; rm_data = db;
  endtask

  task automatic set_ex(input logic w, input logic [4:0] a, input logic [63:0] d);
    exmem_wr = w; exmem_addr = a; exmem_data = d;
  endtask

  task automatic set_wb(input logic w, input logic [4:0] a, input logic [63:0] d);
    memwb_wr = w; memwb_addr = a; memwb_data = d;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    set_ops(5'd0, 64'd0, 5'd0, 64'd0);
    set_ex(1'b0, 5'd0, 64'd0);
    set_wb(1'b0, 5'd0, 64'd0);
    #2;
    check_all("reset", 64'd0, 64'd0, 1'b0, 2'b00, 2'b00, 16'd0);
    step();
    reset = 1'b1;

    // No forward; MEM/WB address equals rn but wr=0 must not match.
    in_valid = 1'b1;
    set_ops(5'd3, 64'h11, 5'd4, 64'h22);
    set_ex(1'b1, 5'd7, 64'hDEAD);
    set_wb(1'b0, 5'd3, 64'hBEEF);
    step();
    check_all("nofwd", 64'h11, 64'h22, 1'b1, 2'b00, 2'b00, 16'd0);

    // Both stages match: EX/MEM wins, two forwards counted.
    set_ops(5'd5, 64'h55, 5'd5, 64'h66);
    set_ex(1'b1, 5'd5, 64'hAAAA);
    set_wb(1'b1, 5'd5, 64'hBBBB);
    step();
    check_all("double", 64'hAAAA, 64'hAAAA, 1'b1, 2'b10, 2'b10, 16'd2);

    // XZR on rn despite EX/MEM match; rm forwarded from MEM/WB only.
    set_ops(5'd31, 64'h77, 5'd6, 64'h88);
    set_ex(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    set_wb(1'b1, 5'd6, 64'h1234);
    step();
    check_all("xzr", 64'd0, 64'h1234, 1'b1, 2'b11, 2'b01, 16'd3);

    // Bubble: operands and tags load, out_valid drops, count frozen.
    in_valid = 1'b0;
    set_ops(5'd2, 64'h22, 5'd9, 64'h99);
    set_ex(1'b1, 5'd2, 64'hC0FFEE);
    set_wb(1'b0, 5'd9, 64'h0);
    step();
    check_all("bubble", 64'hC0FFEE, 64'h99, 1'b0, 2'b10, 2'b00, 16'd3);

    // Valid load then three stalled cycles with changing inputs.
    in_valid = 1'b1;
    set_ops(5'd8, 64'h88, 5'd9, 64'h1);
    set_ex(1'b1, 5'd9, 64'h99);
    set_wb(1'b0, 5'd0, 64'h0);
    step();
    check_all("preload", 64'h88, 64'h99, 1'b1, 2'b00, 2'b10, 16'd4);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_ops(5'(i + 10), 64'(i + 100), 5'(i + 10), 64'(i + 200));
      set_ex(1'b1, 5'(i + 10), 64'(i + 300));
      in_valid = i[0];
      step();
      check_all("stall", 64'h88, 64'h99, 1'b1, 2'b00, 2'b10, 16'd4);
    end
    flush = 1'b1;
    step();
    check_all("flush", 64'd0, 64'd0, 1'b0, 2'b00, 2'b00, 16'd4);
    stall = 1'b0; flush = 1'b0; in_valid = 1'b1;

    // Build count to 7: +2 then +1.
    set_ops(5'd1, 64'h0, 5'd1, 64'h0);
    set_ex(1'b0, 5'd0, 64'h0);
    set_wb(1'b1, 5'd1, 64'h4242);
    step();
    check_all("cnt6", 64'h4242, 64'h4242, 1'b1, 2'b01, 2'b01, 16'd6);
    set_ops(5'd1, 64'h0, 5'd2, 64'h2);
    step();
    check_all("cnt7", 64'h4242, 64'h2, 1'b1, 2'b01, 2'b00, 16'd7);

    // Asynchronous reset between edges, with stall set; held across an edge with flush/valid.
    #2;
    stall = 1'b1;
    reset = 1'b0;
    #1;
    check_all("arst", 64'd0, 64'd0, 1'b0, 2'b00, 2'b00, 16'd0);
    stall = 1'b0; flush = 1'b1;
    step();
    check_all("arst_hold", 64'd0, 64'd0, 1'b0, 2'b00, 2'b00, 16'd0);
    flush = 1'b0;
    set_ops(5'd3, 64'h11, 5'd4, 64'h22);
    set_wb(1'b0, 5'd0, 64'h0);
    #3;
    reset = 1'b1;
    step();
    check_all("arst_rel", 64'h11, 64'h22, 1'b1, 2'b00, 2'b00, 16'd0);

    // Saturation: 32767 double forwards reach FFFE, one more clamps to FFFF, then hold.
    set_ops(5'd12, 64'h0, 5'd12, 64'h0);
    set_ex(1'b1, 5'd12, 64'h5A5A);
    repeat (32767) @(posedge clk);
    #1;
    check("sat_fffe", {48'd0, fwd_count}, 64'hFFFE);
    step();
    check("sat_double", {48'd0, fwd_count}, 64'hFFFF);
    set_ops(5'd12, 64'h0, 5'd13, 64'h0);
    step();
    check("sat_single", {48'd0, fwd_count}, 64'hFFFF);
    check("sat_op_b", op_b, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
